// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester identities.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    EXT  = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, external-requester and memory-side signals of the data-memory arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req_i;
  logic              c_we_i;
  logic [ADDR_W-1:0] c_addr_i;
  logic [DATA_W-1:0] c_wdata_i;
  logic [DATA_W-1:0] c_rdata_o;
  logic              c_stall_o;

  logic              e_req_i;
  logic              e_we_i;
  logic [ADDR_W-1:0] e_addr_i;
  logic [DATA_W-1:0] e_wdata_i;
  logic [DATA_W-1:0] e_rdata_o;
  logic              e_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
    output c_rdata_o, c_stall_o,
    input  e_req_i, e_we_i, e_addr_i, e_wdata_i,
    output e_rdata_o, e_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output c_req_i, c_we_i, c_addr_i, c_wdata_i,
    input  c_rdata_o, c_stall_o,
    output e_req_i, e_we_i, e_addr_i, e_wdata_i,
    input  e_rdata_o, e_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the
// requester that was not granted last. Output is meaningful only when req != 0.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,         // [0] = core, [1] = external
  input  owner_t     last_grant,
  output owner_t     grant
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    grant = CORE;
    if (req == 2'b11)
      grant = (last_grant == CORE) ? EXT : CORE;
    else if (req == 2'b10)
      grant = EXT;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency synchronous data memory between the core's MEM stage
// and an external requester, freezing the core while its access is outstanding.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic           clk,
  input logic           reset,   // asynchronous, active low
  dmem_arbiter_if.slave bus
);

  localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] e_rdata_q, e_rdata_d;
  owner_t            pick;

  rr_pick2 u_pick (
    .req        ({bus.e_req_i, bus.c_req_i}),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    c_rdata_d    = c_rdata_q;
    e_rdata_d    = e_rdata_q;
    case (state_q)
      IDLE: begin
        // The command is captured here so requester changes after grant are ignored.
        if (bus.c_req_i || bus.e_req_i) begin
          state_d = ISSUE;
          owner_d = pick;
          if (pick == CORE) begin
            we_d    = bus.c_we_i;
            addr_d  = bus.c_addr_i;
            wdata_d = bus.c_wdata_i;
          end else begin
            we_d    = bus.e_we_i;
            addr_d  = bus.e_addr_i;
            wdata_d = bus.e_wdata_i;
          end
        end
      end
      ISSUE: begin
        if (MEM_LAT == 1) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        if (!we_q) begin
          if (owner_q == CORE) c_rdata_d = bus.mem_rdata_i;
          else                 e_rdata_d = bus.mem_rdata_i;
        end
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= CORE;
      last_grant_q <= EXT;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      c_rdata_q    <= '0;
      e_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      c_rdata_q    <= c_rdata_d;
      e_rdata_q    <= e_rdata_d;
    end
  end

  // Stall release and read data are combinational so the core advances on the DONE edge.
  assign bus.mem_en_o    = (state_q == ISSUE);
  assign bus.mem_we_o    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.c_stall_o   = bus.c_req_i && !((state_q == DONE) && (owner_q == CORE));
  assign bus.c_rdata_o   = (state_q == DONE) ? bus.mem_rdata_i : c_rdata_q;
  assign bus.e_ack_o     = (state_q == DONE) && (owner_q == EXT);
  assign bus.e_rdata_o   = e_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, multi-cycle corner
// sequences, MEM_LAT=1/4 latency probes and a randomized run against a model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LAT = 2;
  localparam logic [31:0] RD1 = 32'hCAFE_0001;
  localparam logic [31:0] RD4 = 32'hCAFE_0004;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut  (.clk(clk), .reset(rst_n), .bus(bus));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1))   u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4))   u_dut4 (.clk(clk), .reset(rst_n), .bus(bus4));

  assign bus1.mem_rdata_i = RD1;
  assign bus4.mem_rdata_i = RD4;

  // Memory model for the main instance: registered read, unwritten words hold init_val.
  bit [31:0] mem [256];
  bit        wr_vld [256];
  bit [31:0] mem_rd;

  function automatic bit [31:0] init_val(int i);
    return (i == 0) ? 32'h5 : 32'(32'h100 + i);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        mem[bus.mem_addr_o[9:2]]    <= bus.mem_wdata_o;
        wr_vld[bus.mem_addr_o[9:2]] <= 1'b1;
      end else begin
        mem_rd <= wr_vld[bus.mem_addr_o[9:2]] ? mem[bus.mem_addr_o[9:2]] : init_val(int'(bus.mem_addr_o[9:2]));
      end
    end
  end
  assign bus.mem_rdata_i = mem_rd;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req_i = 0; bus.c_we_i = 0; bus.c_addr_i = '0; bus.c_wdata_i = '0;
    bus.e_req_i = 0; bus.e_we_i = 0; bus.e_addr_i = '0; bus.e_wdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // One lone access on the main instance, started right after an edge with the DUT idle.
  task automatic run_single(input bit is_ext, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    int  n = 0;
    int  en_cnt = 0;
    bit  done = 0;
    if (is_ext) begin
      bus.e_req_i = 1; bus.e_we_i = we; bus.e_addr_i = addr; bus.e_wdata_i = wdata;
    end else begin
      bus.c_req_i = 1; bus.c_we_i = we; bus.c_addr_i = addr; bus.c_wdata_i = wdata;
      #1 check({tag, " stall_T"}, 32'(bus.c_stall_o), 32'd1);
    end
    while (!done && n < 20) begin
      tick();
      n++;
      if (bus.mem_en_o) begin
        en_cnt++;
        check({tag, " en_cycle"}, n, 1);
        check({tag, " mem_addr"}, bus.mem_addr_o, addr);
        check({tag, " mem_we"}, 32'(bus.mem_we_o), 32'(we));
        if (we) check({tag, " mem_wdata"}, bus.mem_wdata_o, wdata);
      end
      done = is_ext ? bus.e_ack_o : !bus.c_stall_o;
      if (!is_ext && !done) check({tag, " stall_wait"}, 32'(bus.c_stall_o), 32'd1);
      if (!is_ext && done && !we) check({tag, " c_rdata_pass"}, bus.c_rdata_o, exp_rd);
    end
    check({tag, " latency"}, n, LAT + 1);
    check({tag, " en_count"}, en_cnt, 1);
    tick();
    bus.c_req_i = 0;
    bus.e_req_i = 0;
    #1;
    if (is_ext) check({tag, " e_rdata"}, bus.e_rdata_o, exp_rd);
    else        check({tag, " c_rdata"}, bus.c_rdata_o, exp_rd);
  endtask

  typedef struct {
    bit          is_ext;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  // Reference model state for the randomized phase.
  bit [31:0] ref_mem [256];
  int        m_busy;
  owner_t    m_owner, m_last;
  bit        m_we;
  bit [31:0] m_addr, m_wdata, m_c_rd, m_e_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n4, acks, ack_at, ens;
    bit c_done_edge, e_done_edge, done;

    tbl[0] = '{0, 0, 32'h2000, 32'h0,    32'h5};
    tbl[1] = '{0, 1, 32'h2004, 32'hA,    32'h5};
    tbl[2] = '{1, 0, 32'h2004, 32'h0,    32'hA};
    tbl[3] = '{1, 1, 32'h2008, 32'h55AA, 32'hA};
    tbl[4] = '{0, 0, 32'h2008, 32'h0,    32'h55AA};
    tbl[5] = '{1, 0, 32'h200C, 32'h0,    32'h103};
    tbl[6] = '{0, 1, 32'h200C, 32'hDEAD, 32'h55AA};
    tbl[7] = '{1, 0, 32'h200C, 32'h0,    32'hDEAD};

    idle_inputs();
    bus1.c_req_i = 0; bus1.c_we_i = 0; bus1.c_addr_i = '0; bus1.c_wdata_i = '0;
    bus1.e_req_i = 0; bus1.e_we_i = 0; bus1.e_addr_i = '0; bus1.e_wdata_i = '0;
    bus4.c_req_i = 0; bus4.c_we_i = 0; bus4.c_addr_i = '0; bus4.c_wdata_i = '0;
    bus4.e_req_i = 0; bus4.e_we_i = 0; bus4.e_addr_i = '0; bus4.e_wdata_i = '0;

    // Reset values, with the stall following c_req_i.
    repeat (2) tick();
    bus.c_req_i = 1;
    #1;
    check("rst mem_en", 32'(bus.mem_en_o), 0);
    check("rst mem_we", 32'(bus.mem_we_o), 0);
    check("rst mem_addr", bus.mem_addr_o, 0);
    check("rst mem_wdata", bus.mem_wdata_o, 0);
    check("rst e_ack", 32'(bus.e_ack_o), 0);
    check("rst c_rdata", bus.c_rdata_o, 0);
    check("rst e_rdata", bus.e_rdata_o, 0);
    check("rst stall_hi", 32'(bus.c_stall_o), 1);
    bus.c_req_i = 0;
    #1 check("rst stall_lo", 32'(bus.c_stall_o), 0);
    tick();
    rst_n = 1'b1;

    // MEM_LAT=1 and MEM_LAT=4 builds: DONE at T+2 and T+5.
    bus1.c_req_i = 1; bus1.c_addr_i = 32'h2000;
    bus4.c_req_i = 1; bus4.c_addr_i = 32'h2000;
    n1 = 0; n4 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (n1 == 0 && !bus1.c_stall_o) begin
        n1 = k;
        check("lat1 c_rdata", bus1.c_rdata_o, RD1);
      end else if (n1 != 0) bus1.c_req_i = 0;
      if (n4 == 0 && !bus4.c_stall_o) begin
        n4 = k;
        check("lat4 c_rdata", bus4.c_rdata_o, RD4);
      end else if (n4 != 0) bus4.c_req_i = 0;
    end
    check("lat1 done_cycle", n1, 2);
    check("lat4 done_cycle", n4, 5);
    bus1.c_req_i = 0;
    bus4.c_req_i = 0;

    // Directed table of lone accesses.
    for (int i = 0; i < 8; i++)
      run_single(tbl[i].is_ext, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd,
                 $sformatf("vec%0d", i));

    // Tie from reset: core first, ext ISSUE at core DONE+2, then ext beats the core's next request.
    do_reset();
    bus.c_req_i = 1; bus.c_addr_i = 32'h2010;
    bus.e_req_i = 1; bus.e_addr_i = 32'h2014;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("tie en@%0d", k), 32'(bus.mem_en_o), 32'(k == 1 || k == 5 || k == 9));
      check($sformatf("tie ack@%0d", k), 32'(bus.e_ack_o), 32'(k == 7));
      if (k <= 12) check($sformatf("tie stall@%0d", k), 32'(bus.c_stall_o), 32'(k != 3 && k != 11));
      if (k == 1) check("tie addr1", bus.mem_addr_o, 32'h2010);
      if (k == 5) check("tie addr2", bus.mem_addr_o, 32'h2014);
      if (k == 9) check("tie addr3", bus.mem_addr_o, 32'h2018);
      if (k == 4)  bus.c_addr_i = 32'h2018;
      if (k == 8)  bus.e_req_i = 0;
      if (k == 12) bus.c_req_i = 0;
    end
    check("tie e_rdata", bus.e_rdata_o, 32'h105);
    check("tie c_rdata", bus.c_rdata_o, 32'h106);

    // External requester drops e_req_i during WAIT: access completes, one ack.
    bus.e_req_i = 1; bus.e_we_i = 0; bus.e_addr_i = 32'h2008;
    acks = 0; ack_at = 0; ens = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.e_ack_o) begin acks++; ack_at = k; end
      if (bus.mem_en_o) ens++;
      if (k == 2) bus.e_req_i = 0;
    end
    check("drop ack_count", acks, 1);
    check("drop ack_cycle", ack_at, LAT + 1);
    check("drop en_count", ens, 1);
    check("drop e_rdata", bus.e_rdata_o, 32'h55AA);

    // Reset during WAIT: outputs return to reset values at once, no ack follows.
    bus.e_req_i = 1; bus.e_we_i = 0; bus.e_addr_i = 32'h200C;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst mem_en", 32'(bus.mem_en_o), 0);
    check("mid_rst mem_addr", bus.mem_addr_o, 0);
    check("mid_rst e_ack", 32'(bus.e_ack_o), 0);
    check("mid_rst c_rdata", bus.c_rdata_o, 0);
    check("mid_rst e_rdata", bus.e_rdata_o, 0);
    check("mid_rst stall", 32'(bus.c_stall_o), 0);
    bus.e_req_i = 0;
    acks = 0; ens = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 2) rst_n = 1'b1;
      acks += int'(bus.e_ack_o);
      ens  += int'(bus.mem_en_o);
    end
    check("mid_rst no_ack", acks, 0);
    check("mid_rst no_en", ens, 0);
    run_single(0, 0, 32'h200C, 32'h0, 32'hDEAD, "post_rst");

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = wr_vld[i] ? mem[i] : init_val(i);
    m_busy = 0; m_last = EXT; m_owner = CORE; m_c_rd = 0; m_e_rd = 0;
    m_we = 0; m_addr = 0; m_wdata = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      c_done_edge = 0;
      e_done_edge = 0;
      if (m_busy > 0) begin
        if (m_busy == 1) begin
          if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
          else if (m_owner == CORE) m_c_rd = ref_mem[m_addr[9:2]];
          else m_e_rd = ref_mem[m_addr[9:2]];
          m_last = m_owner;
          if (m_owner == CORE) c_done_edge = 1; else e_done_edge = 1;
        end
        m_busy--;
      end else if (bus.c_req_i || bus.e_req_i) begin
        if (bus.c_req_i && bus.e_req_i) m_owner = (m_last == CORE) ? EXT : CORE;
        else                            m_owner = bus.c_req_i ? CORE : EXT;
        m_we    = (m_owner == CORE) ? bus.c_we_i    : bus.e_we_i;
        m_addr  = (m_owner == CORE) ? bus.c_addr_i  : bus.e_addr_i;
        m_wdata = (m_owner == CORE) ? bus.c_wdata_i : bus.e_wdata_i;
        m_busy  = LAT + 1;
      end
      if (!bus.c_req_i || c_done_edge) begin
        bus.c_req_i   = ($urandom_range(0, 3) != 0);
        bus.c_we_i    = $urandom_range(0, 1);
        bus.c_addr_i  = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        bus.c_wdata_i = $urandom;
      end
      if (!bus.e_req_i || e_done_edge) begin
        bus.e_req_i   = ($urandom_range(0, 2) == 0);
        bus.e_we_i    = $urandom_range(0, 1);
        bus.e_addr_i  = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        bus.e_wdata_i = $urandom;
      end
      #1;
      done = (m_busy == 1);
      check("rnd en", 32'(bus.mem_en_o), 32'(m_busy == LAT + 1));
      check("rnd ack", 32'(bus.e_ack_o), 32'(done && m_owner == EXT));
      check("rnd stall", 32'(bus.c_stall_o), 32'(bus.c_req_i && !(done && m_owner == CORE)));
      check("rnd e_rdata", bus.e_rdata_o, m_e_rd);
      if (m_busy == LAT + 1) begin
        check("rnd mem_addr", bus.mem_addr_o, m_addr);
        check("rnd mem_we", 32'(bus.mem_we_o), 32'(m_we));
        if (m_we) check("rnd mem_wdata", bus.mem_wdata_o, m_wdata);
      end
      if (done && !m_we) check("rnd c_rdata_pass", bus.c_rdata_o, ref_mem[m_addr[9:2]]);
      else if (!done)    check("rnd c_rdata", bus.c_rdata_o, m_c_rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
